// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch: one-outstanding imem requester with a 2-entry instruction FIFO
module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic [5:0]  ct_inst,
    output logic [5:0]  aluct_inst
);

    localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, WAIT, DROP} state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } entry_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_addr;
    entry_t      head;
    entry_t      tail;
    logic [1:0]  count;

    logic        pop;
    logic        push;
    logic        issue;
    logic [1:0]  count_after_pop;
    entry_t      new_entry;

    // Redirect overrides everything: no pop, no push, no issue in that cycle.
    assign pop             = inst_valid && inst_ready && !redirect_valid;
    assign count_after_pop = count - {1'b0, pop};
    assign issue           = (state == RUN) && !redirect_valid && (count_after_pop < DEPTH);
    assign push            = (state == WAIT) && imem_rvalid && !redirect_valid
                             && (count_after_pop != DEPTH);
    assign new_entry       = '{data: imem_rdata, pc: req_addr};

    assign imem_req   = issue;
    assign imem_addr  = issue ? pc : 32'h0;
    assign inst_valid = (count != 2'd0);
    assign inst_out   = inst_valid ? head.data : 32'h0;
    assign inst_pc    = inst_valid ? head.pc : 32'h0;
    assign ct_inst    = inst_out[31:26];
    assign aluct_inst = inst_out[5:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_addr <= 32'h0;
            head     <= '0;
            tail     <= '0;
            count    <= 2'd0;
        end else begin
            case (state)
                IDLE: state <= RUN;
                RUN:  if (issue) state <= WAIT;
                WAIT: begin
                    if (imem_rvalid)         state <= RUN;
                    else if (redirect_valid) state <= DROP;
                end
                DROP: if (imem_rvalid) state <= RUN;
                default: state <= IDLE;
            endcase

            if (redirect_valid) begin
                pc <= {redirect_pc[31:2], 2'b00};
            end else if (issue) begin
                pc       <= pc + 32'd4;
                req_addr <= pc;
            end

            if (redirect_valid) begin
                count <= 2'd0;
            end else begin
                case ({push, pop})
                    2'b01: begin
                        head  <= tail;
                        count <= count - 2'd1;
                    end
                    2'b10: begin
                        if (count == 2'd0) head <= new_entry;
                        else               tail <= new_entry;
                        count <= count + 2'd1;
                    end
                    2'b11: begin
                        // Pop and push together: the new word lands behind whatever survives the pop.
                        if (count == 2'd1) begin
                            head <= new_entry;
                        end else begin
                            head <= tail;
                            tail <= new_entry;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC   = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_rvalid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid, inst_ready = 1'b0;
    logic [31:0] inst_out, inst_pc;
    logic [5:0]  ct_inst, aluct_inst;

    logic        w_req, w_valid;
    logic [31:0] w_addr, w_out, w_ipc;
    logic [5:0]  w_ct, w_aluct;

    inst_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_out(inst_out), .inst_pc(inst_pc),
        .ct_inst(ct_inst), .aluct_inst(aluct_inst)
    );

    inst_fetch #(.RESET_PC(WRAP_PC), .FIFO_DEPTH(2)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(w_valid), .inst_ready(inst_ready),
        .inst_out(w_out), .inst_pc(w_ipc),
        .ct_inst(w_ct), .aluct_inst(w_aluct)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_out_addr;
    bit          m_out;
    bit          m_drop;

    bit          pend_v;
    logic [31:0] pend_addr;
    int          pend_due;
    int          mem_lat = 1;

    int          req_count;
    logic [31:0] dut_pops[$];

    typedef struct packed {
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h8C41_0004;
        return a * 32'h9E37_79B1 + 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset(input bit stale);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_req",   32'(imem_req), 32'h0);
        check("rst_addr",  imem_addr, 32'h0);
        check("rst_valid", 32'(inst_valid), 32'h0);
        check("rst_out",   inst_out, 32'h0);
        check("rst_pc",    inst_pc, 32'h0);
        check("rst_ctl",   32'({ct_inst, aluct_inst}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        imem_rvalid    = stale;
        imem_rdata     = 32'h0BAD_0BAD;
        #1;
        check("idle_req",   32'(imem_req), 32'h0);
        check("idle_valid", 32'(inst_valid), 32'h0);
        mq.delete();
        m_pc   = RESET_PC;
        m_out  = 1'b0;
        m_drop = 1'b0;
        pend_v = 1'b0;
        cyc++;
    endtask

    task automatic cycle(input logic redir, input logic [31:0] rpc, input logic rdy);
        logic        rv;
        logic [31:0] rd;
        logic        e_valid, e_req, pop;
        logic [31:0] e_inst, e_ipc, e_addr;
        int          occ;
        @(negedge clk);
        rv = 1'b0;
        rd = 32'h0;
        if (pend_v && pend_due <= cyc) begin
            rv     = 1'b1;
            rd     = mem_word(pend_addr);
            pend_v = 1'b0;
        end
        redirect_valid = redir;
        redirect_pc    = rpc;
        inst_ready     = rdy;
        imem_rvalid    = rv;
        imem_rdata     = rd;
        #1;
        e_valid = (mq.size() > 0);
        e_inst  = e_valid ? mq[0].data : 32'h0;
        e_ipc   = e_valid ? mq[0].pc : 32'h0;
        pop     = e_valid && rdy && !redir;
        occ     = mq.size() - (pop ? 1 : 0);
        e_req   = !redir && !m_out && (occ < 2);
        e_addr  = e_req ? m_pc : 32'h0;

        check("req",    32'(imem_req), 32'(e_req));
        check("addr",   imem_addr, e_addr);
        check("valid",  32'(inst_valid), 32'(e_valid));
        check("inst",   inst_out, e_inst);
        check("pc",     inst_pc, e_ipc);
        check("ct",     32'(ct_inst), 32'(e_inst[31:26]));
        check("aluct",  32'(aluct_inst), 32'(e_inst[5:0]));
        check("w_req",  32'(w_req), 32'(e_req));

        if (imem_req) req_count++;
        if (inst_valid && rdy && !redir) dut_pops.push_back(inst_pc);

        if (redir) begin
            mq.delete();
            m_pc = {rpc[31:2], 2'b00};
            if (rv) begin
                m_out  = 1'b0;
                m_drop = 1'b0;
            end else if (m_out) begin
                m_drop = 1'b1;
            end
        end else begin
            if (pop) void'(mq.pop_front());
            if (rv && m_out) begin
                if (!m_drop) mq.push_back('{rd, m_out_addr});
                m_out  = 1'b0;
                m_drop = 1'b0;
            end
            if (e_req) begin
                m_out      = 1'b1;
                m_out_addr = m_pc;
                m_pc       = m_pc + 32'd4;
                pend_v     = 1'b1;
                pend_addr  = m_out_addr;
                pend_due   = cyc + mem_lat;
            end
        end
        cyc++;
    endtask

    initial begin
        logic [31:0] w_exp;

        //          redir  rpc          rdy  rv   rdata          e_req e_addr        e_val e_pc          e_inst
        vecs[0]  = '{1'b0, 32'h0,       1'b1,1'b0,32'h0,         1'b1, 32'h0000_0000,1'b0, 32'h0,        32'h0};
        vecs[1]  = '{1'b0, 32'h0,       1'b1,1'b1,32'h8C41_0004, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0};
        vecs[2]  = '{1'b0, 32'h0,       1'b1,1'b0,32'h0,         1'b1, 32'h0000_0004,1'b1, 32'h0000_0000,32'h8C41_0004};
        vecs[3]  = '{1'b0, 32'h0,       1'b1,1'b1,32'hA000_0001, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0};
        vecs[4]  = '{1'b0, 32'h0,       1'b1,1'b0,32'h0,         1'b1, 32'h0000_0008,1'b1, 32'h0000_0004,32'hA000_0001};
        vecs[5]  = '{1'b0, 32'h0,       1'b1,1'b1,32'hA000_0002, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0};
        vecs[6]  = '{1'b0, 32'h0,       1'b1,1'b0,32'h0,         1'b1, 32'h0000_000C,1'b1, 32'h0000_0008,32'hA000_0002};
        vecs[7]  = '{1'b1, 32'h0000_0043,1'b1,1'b0,32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h0};
        vecs[8]  = '{1'b0, 32'h0,       1'b1,1'b1,32'hDEAD_BEEF, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0};
        vecs[9]  = '{1'b0, 32'h0,       1'b1,1'b0,32'h0,         1'b1, 32'h0000_0040,1'b0, 32'h0,        32'h0};
        vecs[10] = '{1'b1, 32'h0000_0100,1'b1,1'b1,32'hCAFE_F00D,1'b0, 32'h0,        1'b0, 32'h0,        32'h0};
        vecs[11] = '{1'b0, 32'h0,       1'b1,1'b0,32'h0,         1'b1, 32'h0000_0100,1'b0, 32'h0,        32'h0};
        vecs[12] = '{1'b0, 32'h0,       1'b1,1'b1,32'h1111_1111, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0};
        vecs[13] = '{1'b0, 32'h0,       1'b1,1'b0,32'h0,         1'b1, 32'h0000_0104,1'b1, 32'h0000_0100,32'h1111_1111};

        do_reset(1'b0);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            inst_ready     = vecs[i].rdy;
            imem_rvalid    = vecs[i].rv;
            imem_rdata     = vecs[i].rdata;
            #1;
            check($sformatf("v%0d_req", i),   32'(imem_req), 32'(vecs[i].e_req));
            check($sformatf("v%0d_addr", i),  imem_addr, vecs[i].e_addr);
            check($sformatf("v%0d_valid", i), 32'(inst_valid), 32'(vecs[i].e_valid));
            check($sformatf("v%0d_pc", i),    inst_pc, vecs[i].e_pc);
            check($sformatf("v%0d_inst", i),  inst_out, vecs[i].e_inst);
            check($sformatf("v%0d_ct", i),    32'(ct_inst), 32'(vecs[i].e_inst[31:26]));
            check($sformatf("v%0d_aluct", i), 32'(aluct_inst), 32'(vecs[i].e_inst[5:0]));
            // The wrap instance starts 4 below zero, so until the first redirect it trails by 4.
            w_exp = !vecs[i].e_req ? 32'h0 : (i < 7 ? vecs[i].e_addr - 32'd4 : vecs[i].e_addr);
            check($sformatf("v%0d_wrap_addr", i), w_addr, w_exp);
            cyc++;
        end

        // Backpressure: two entries buffered, then drain in order.
        do_reset(1'b0);
        mem_lat   = 1;
        req_count = 0;
        repeat (12) cycle(1'b0, 32'h0, 1'b0);
        check("bp_reqs", 32'(req_count), 32'd2);
        check("bp_valid", 32'(inst_valid), 32'h1);
        dut_pops.delete();
        repeat (16) cycle(1'b0, 32'h0, 1'b1);
        check("bp_pop_count", 32'(dut_pops.size() >= 6), 32'h1);
        for (int k = 0; k < dut_pops.size(); k++)
            check($sformatf("bp_pop%0d", k), dut_pops[k], 32'(k * 4));

        // Reset while a request is outstanding; late responses must be ignored.
        do_reset(1'b0);
        mem_lat = 3;
        cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        do_reset(1'b1);
        pend_v    = 1'b1;
        pend_addr = 32'h0BAD_0000;
        pend_due  = cyc;
        cycle(1'b0, 32'h0, 1'b1);
        check("rst_new_addr", imem_addr, RESET_PC);
        check("rst_new_req", 32'(imem_req), 32'h1);
        repeat (3) cycle(1'b0, 32'h0, 1'b1);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 199) == 0) do_reset(1'($urandom_range(0, 1)));
            mem_lat = $urandom_range(1, 3);
            cycle(1'($urandom_range(0, 19) == 0), $urandom, 1'($urandom_range(0, 9) < 7));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC loaded on reset.
REQ-002 Parameter FIFO_DEPTH, 2, instruction buffer entries; fixed at 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 imem_req  output  1  one-cycle fetch request pulse to instruction memory.
REQ-006 imem_addr  output  32  fetch address; valid when imem_req=1.
REQ-007 imem_rvalid  input  1  response strobe; in order; at least 1 cycle after its request.
REQ-008 imem_rdata  input  32  instruction word; valid when imem_rvalid=1.
REQ-009 redirect_valid  input  1  taken branch or jump from the execute side; one-cycle pulse.
REQ-010 redirect_pc  input  32  redirect target; sampled when redirect_valid=1.
REQ-011 inst_valid  output  1  FIFO head holds an instruction for the decoder.
REQ-012 inst_ready  input  1  decoder consumes the head this cycle.
REQ-013 inst_out  output  32  FIFO head instruction word.
REQ-014 inst_pc  output  32  address of inst_out.
REQ-015 ct_inst  output  6  inst_out[31:26], opcode field for the control decoder.
REQ-016 aluct_inst  output  6  inst_out[5:0], funct field for the ALU control decoder.

Function
REQ-017 State machine states: IDLE, RUN, WAIT, DROP.
- IDLE: entered on reset; moves to RUN on the first clock edge after rst deasserts; no request is issued in IDLE.
- RUN: may issue a request.
- WAIT: one request is outstanding.
- DROP: one request is outstanding and its response is to be discarded.
REQ-018 At most one request is outstanding at any time.
REQ-019 Issue condition: state RUN, redirect_valid=0, and FIFO occupancy after this cycle's pop is less than FIFO_DEPTH.
REQ-020 On issue:
- imem_req=1 and imem_addr=pc for exactly one cycle.
- pc <= pc+4, modulo 2^32 (wraps 32'hFFFF_FFFC -> 0).
- State moves to WAIT.
REQ-021 In WAIT, imem_rvalid=1 pushes {imem_rdata, request address} into the FIFO and the state returns to RUN; the entry becomes visible on inst_valid the next cycle.
REQ-022 Minimum latency from imem_req to inst_valid is 2 cycles (response 1 cycle after the request, plus the registered push).
REQ-023 Pop: inst_valid=1 and inst_ready=1 removes the head at the clock edge; inst_ready is ignored when inst_valid=0.
REQ-024 A simultaneous push and pop leaves occupancy unchanged and preserves order.
REQ-025 When the FIFO is empty, inst_valid=0 and inst_out, inst_pc, ct_inst and aluct_inst are all 0.
REQ-026 redirect_valid=1 has highest priority; in that cycle:
- the FIFO is flushed and no pop is counted;
- pc <= {redirect_pc[31:2], 2'b00};
- no request is issued.
REQ-027 Redirect state transitions:
- RUN -> RUN.
- WAIT -> DROP.
- DROP -> DROP.
- WAIT with imem_rvalid=1 in the same cycle -> RUN, and the response is discarded.
REQ-028 In DROP, imem_rvalid=1 discards the response (no push) and the state moves to RUN.
REQ-029 imem_rvalid=1 in RUN or IDLE is ignored (protocol violation, no state change).

Reset
REQ-030 While rst=1, independent of clk:
- pc=RESET_PC, state=IDLE, FIFO empty;
- imem_req=0, imem_addr=0;
- inst_valid=0, and inst_out, inst_pc, ct_inst, aluct_inst are all 0.
REQ-031 Assertion of rst mid-operation abandons any outstanding request; a response arriving after reset deasserts is ignored under REQ-029 because the state is then IDLE or RUN.

Verification
REQ-032 Release reset, memory latency 1 cycle, inst_ready=1 held -> requests at 0x0, 0x4, 0x8 every 2 cycles; inst_pc sequence 0x0, 0x4, 0x8; instruction word 0x8C410004 gives ct_inst=6'h23.
REQ-033 inst_ready=0 held -> exactly 2 entries buffered, no third imem_req; raising inst_ready resumes fetch in order with no loss or duplication.
REQ-034 redirect_valid=1 with redirect_pc=0x0000_0043 while WAIT -> the next response is dropped, the FIFO is flushed, and the next request address is 0x0000_0040.
REQ-035 redirect_valid=1 in the same cycle as imem_rvalid=1 -> no push, state RUN, and the next imem_addr equals the redirect target.
REQ-036 Force pc=0xFFFF_FFFC (RESET_PC=0xFFFF_FFFC) -> second request address is 0x0000_0000.
REQ-037 Assert rst during WAIT, then deassert and pulse imem_rvalid -> inst_valid stays 0 and the first new imem_addr is RESET_PC.
